// File: rtl/hard_mem_arb_pkg.sv
// Shared types and sizes for the two-port arbiter in front of the 1024x46 1RW hard SRAM.
package hard_mem_arb_pkg;

    localparam int unsigned width_p      = 46;
    localparam int unsigned els_p        = 1024;
    localparam int unsigned addr_width_p = $clog2(els_p);

    typedef enum logic {eINIT, eRUN} arb_state_e;

    typedef struct packed {
        logic                    w;
        logic [addr_width_p-1:0] addr;
        logic [width_p-1:0]      data;
    } mem_req_s;

endpackage

// File: rtl/hard_mem_arb_resp_slot.sv
// Per-port read response slot: tracks the in-flight read, captures SRAM data
// one cycle after accept and holds it under a valid/yumi handshake.
module hard_mem_arb_resp_slot
    import hard_mem_arb_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               accept_i,
    input  logic [width_p-1:0] mem_data_i,
    input  logic               yumi_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               eligible_o
);

    logic pend_q;

    // A pending read always lands in an empty slot: the accept required the slot
    // to be empty or draining in that same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend_q <= 1'b0;
            v_o    <= 1'b0;
            data_o <= '0;
        end else begin
            pend_q <= accept_i;
            if (pend_q) begin
                v_o    <= 1'b1;
                data_o <= mem_data_i;
            end else if (yumi_i) begin
                v_o    <= 1'b0;
            end
        end
    end

    assign eligible_o = !pend_q && (!v_o || yumi_i);

endmodule

// File: rtl/hard_mem_1rw_d1024_w46_arb.sv
// Round-robin two-port arbiter onto a single 1RW 1024x46 SRAM with registered read responses.
// Define HARD_MEM_ARB_ZERO_INIT_EN to zero-fill the memory after reset before accepting requests.
module hard_mem_1rw_d1024_w46_arb
    import hard_mem_arb_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    p0_v_i,
    input  logic                    p0_w_i,
    input  logic [addr_width_p-1:0] p0_addr_i,
    input  logic [width_p-1:0]      p0_data_i,
    output logic                    p0_yumi_o,
    output logic                    p0_v_o,
    output logic [width_p-1:0]      p0_data_o,
    input  logic                    p0_yumi_i,

    input  logic                    p1_v_i,
    input  logic                    p1_w_i,
    input  logic [addr_width_p-1:0] p1_addr_i,
    input  logic [width_p-1:0]      p1_data_i,
    output logic                    p1_yumi_o,
    output logic                    p1_v_o,
    output logic [width_p-1:0]      p1_data_o,
    input  logic                    p1_yumi_i,

    output logic                    mem_v_o,
    output logic                    mem_w_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output logic [width_p-1:0]      mem_data_o,
    input  logic [width_p-1:0]      mem_data_i,

    output logic                    init_done_o
);

    mem_req_s                req0_c, req1_c, mem_req_c;
    logic                    run_c, init_wr_c;
    logic [addr_width_p-1:0] init_addr_c;
    logic                    elig0_c, elig1_c;
    logic                    req0_v_c, req1_v_c;
    logic                    gnt0_c, gnt1_c;
    logic                    rr_last_q;

`ifdef HARD_MEM_ARB_ZERO_INIT_EN
    arb_state_e              state_q, state_n;
    logic [addr_width_p-1:0] cnt_q, cnt_n;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eINIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Sweep every address once with a zero write, then hand the memory to the ports.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        if (state_q == eINIT) begin
            cnt_n = cnt_q + addr_width_p'(1);
            if (cnt_q == addr_width_p'(els_p - 1)) begin
                state_n = eRUN;
            end
        end
    end

    assign run_c       = (state_q == eRUN);
    assign init_wr_c   = (state_q == eINIT) && reset_n_i;
    assign init_addr_c = cnt_q;
`else
    assign run_c       = reset_n_i;
    assign init_wr_c   = 1'b0;
    assign init_addr_c = '0;
`endif

    assign req0_c = {p0_w_i, p0_addr_i, p0_data_i};
    assign req1_c = {p1_w_i, p1_addr_i, p1_data_i};

    // Writes never need a response slot, so only reads are gated by eligibility.
    assign req0_v_c = p0_v_i && (p0_w_i || elig0_c);
    assign req1_v_c = p1_v_i && (p1_w_i || elig1_c);

    assign gnt0_c = run_c && req0_v_c && (!req1_v_c ||  rr_last_q);
    assign gnt1_c = run_c && req1_v_c && (!req0_v_c || !rr_last_q);

    assign p0_yumi_o   = gnt0_c;
    assign p1_yumi_o   = gnt1_c;
    assign init_done_o = run_c;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_last_q <= 1'b1;
        end else if (gnt0_c || gnt1_c) begin
            rr_last_q <= gnt1_c;
        end
    end

    always_comb begin
        mem_req_c = '0;
        mem_v_o   = 1'b0;
        if (init_wr_c) begin
            mem_v_o        = 1'b1;
            mem_req_c.w    = 1'b1;
            mem_req_c.addr = init_addr_c;
        end else if (gnt0_c) begin
            mem_v_o   = 1'b1;
            mem_req_c = req0_c;
        end else if (gnt1_c) begin
            mem_v_o   = 1'b1;
            mem_req_c = req1_c;
        end
    end

    assign mem_w_o    = mem_req_c.w;
    assign mem_addr_o = mem_req_c.addr;
    assign mem_data_o = mem_req_c.data;

    hard_mem_arb_resp_slot u_slot0 (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .accept_i   (gnt0_c && !p0_w_i),
        .mem_data_i (mem_data_i),
        .yumi_i     (p0_yumi_i),
        .v_o        (p0_v_o),
        .data_o     (p0_data_o),
        .eligible_o (elig0_c)
    );

    hard_mem_arb_resp_slot u_slot1 (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .accept_i   (gnt1_c && !p1_w_i),
        .mem_data_i (mem_data_i),
        .yumi_i     (p1_yumi_i),
        .v_o        (p1_v_o),
        .data_o     (p1_data_o),
        .eligible_o (elig1_c)
    );

endmodule

// File: tb/tb_hard_mem_1rw_d1024_w46_arb.sv
// Directed bench for hard_mem_1rw_d1024_w46_arb with a behavioural 1RW SRAM behind it.
module tb_hard_mem_1rw_d1024_w46_arb;

    logic        clk;
    logic        reset_n;
    logic        p0_v, p0_w, p0_yumi_o, p0_v_o, p0_yumi_i;
    logic [9:0]  p0_addr;
    logic [45:0] p0_data, p0_data_o;
    logic        p1_v, p1_w, p1_yumi_o, p1_v_o, p1_yumi_i;
    logic [9:0]  p1_addr;
    logic [45:0] p1_data, p1_data_o;
    logic        mem_v, mem_w, init_done;
    logic [9:0]  mem_addr;
    logic [45:0] mem_wdata, mem_rdata;
    logic [45:0] sram [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [45:0] D_VAL = 46'h2A_BCDE_F012;
    localparam logic [45:0] A_VAL = 46'h12_3456_789A;
    localparam logic [45:0] B_VAL = 46'h3F_0000_00FF;
    localparam logic [45:0] E_VAL = 46'h15_5555_AAAA;

    hard_mem_1rw_d1024_w46_arb dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .p0_v_i      (p0_v),
        .p0_w_i      (p0_w),
        .p0_addr_i   (p0_addr),
        .p0_data_i   (p0_data),
        .p0_yumi_o   (p0_yumi_o),
        .p0_v_o      (p0_v_o),
        .p0_data_o   (p0_data_o),
        .p0_yumi_i   (p0_yumi_i),
        .p1_v_i      (p1_v),
        .p1_w_i      (p1_w),
        .p1_addr_i   (p1_addr),
        .p1_data_i   (p1_data),
        .p1_yumi_o   (p1_yumi_o),
        .p1_v_o      (p1_v_o),
        .p1_data_o   (p1_data_o),
        .p1_yumi_i   (p1_yumi_i),
        .mem_v_o     (mem_v),
        .mem_w_o     (mem_w),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdata),
        .mem_data_i  (mem_rdata),
        .init_done_o (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (mem_v) begin
            if (mem_w) sram[mem_addr] <= mem_wdata;
            else       mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        p0_v = 1'b0; p0_w = 1'b0; p0_addr = '0; p0_data = '0; p0_yumi_i = 1'b0;
        p1_v = 1'b0; p1_w = 1'b0; p1_addr = '0; p1_data = '0; p1_yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        idle();
        p0_v = 1'b1; p0_w = 1'b1; p1_v = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (p0_yumi_o !== 1'b0) begin n_fail++; $display("FAIL reset_p0_yumi: got %b want 0", p0_yumi_o); end
        n_checks++; if (p1_yumi_o !== 1'b0) begin n_fail++; $display("FAIL reset_p1_yumi: got %b want 0", p1_yumi_o); end
        n_checks++; if (mem_v !== 1'b0) begin n_fail++; $display("FAIL reset_mem_v: got %b want 0", mem_v); end
        n_checks++; if (p0_v_o !== 1'b0 || p1_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v_o: got %b%b want 00", p0_v_o, p1_v_o); end
        n_checks++; if (p0_data_o !== '0 || p1_data_o !== '0) begin n_fail++; $display("FAIL reset_data_o: got %h %h want 0", p0_data_o, p1_data_o); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        idle();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_init();
`ifdef HARD_MEM_ARB_ZERO_INIT_EN
        p0_v = 1'b1; p0_w = 1'b1; p1_v = 1'b1; p1_w = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            #1;
            n_checks++;
            if (mem_v !== 1'b1 || mem_w !== 1'b1 || mem_addr !== 10'(i) || mem_wdata !== '0 ||
                p0_yumi_o !== 1'b0 || p1_yumi_o !== 1'b0 || init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL init_write[%0d]: got v=%b w=%b addr=%0d data=%h yumi=%b%b done=%b want 1 1 %0d 0 00 0",
                         i, mem_v, mem_w, mem_addr, mem_wdata, p0_yumi_o, p1_yumi_o, init_done, i);
            end
            @(negedge clk);
        end
        idle();
        #1;
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_1024: got %b want 1", init_done); end
        step();
        p1_v = 1'b1; p1_w = 1'b0; p1_addr = 10'd5;
        settle();
        n_checks++; if (p1_yumi_o !== 1'b1) begin n_fail++; $display("FAIL init_rd5_yumi: got %b want 1", p1_yumi_o); end
        step();
        p1_v = 1'b0;
        step();
        settle();
        n_checks++; if (p1_v_o !== 1'b1 || p1_data_o !== '0) begin n_fail++; $display("FAIL init_rd5_data: got v=%b %h want 1 0", p1_v_o, p1_data_o); end
        step();
        p1_yumi_i = 1'b1;
        step();
        p1_yumi_i = 1'b0;
`else
        #1;
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_run: got %b want 1", init_done); end
`endif
    endtask

    task automatic test_round_robin();
        logic exp0;
        step();
        p0_v = 1'b1; p0_w = 1'b1; p0_addr = 10'd3; p0_data = A_VAL;
        p1_v = 1'b1; p1_w = 1'b1; p1_addr = 10'd4; p1_data = B_VAL;
        p0_yumi_i = 1'b1; p1_yumi_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            exp0 = (i % 2 == 0);
            n_checks++;
            if (p0_yumi_o !== exp0 || p1_yumi_o !== !exp0) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b%b want %b%b", i, p0_yumi_o, p1_yumi_o, exp0, !exp0);
            end
            n_checks++;
            if (mem_addr !== (exp0 ? 10'd3 : 10'd4) || mem_wdata !== (exp0 ? A_VAL : B_VAL)) begin
                n_fail++; $display("FAIL rr_mem[%0d]: got addr=%0d data=%h want %0d", i, mem_addr, mem_wdata, exp0 ? 3 : 4);
            end
            n_checks++;
            if (p0_v_o !== 1'b0 || p1_v_o !== 1'b0) begin
                n_fail++; $display("FAIL rr_stray_yumi[%0d]: got v_o=%b%b want 00", i, p0_v_o, p1_v_o);
            end
            step();
        end
        idle();
    endtask

    task automatic test_write_read();
        p0_v = 1'b1; p0_w = 1'b1; p0_addr = 10'd17; p0_data = D_VAL;
        settle();
        n_checks++;
        if (p0_yumi_o !== 1'b1 || mem_v !== 1'b1 || mem_w !== 1'b1 || mem_addr !== 10'd17 || mem_wdata !== D_VAL) begin
            n_fail++; $display("FAIL wr17: got yumi=%b v=%b w=%b addr=%0d data=%h want 1 1 1 17 %h",
                               p0_yumi_o, mem_v, mem_w, mem_addr, mem_wdata, D_VAL);
        end
        step();
        p0_w = 1'b0;
        settle();
        n_checks++; if (p0_yumi_o !== 1'b1 || mem_w !== 1'b0) begin n_fail++; $display("FAIL rd17_accept: got yumi=%b w=%b want 1 0", p0_yumi_o, mem_w); end
        step();
        p0_v = 1'b0;
        settle();
        n_checks++; if (p0_v_o !== 1'b0) begin n_fail++; $display("FAIL rd17_early: got v_o=%b want 0", p0_v_o); end
        step();
        settle();
        n_checks++; if (p0_v_o !== 1'b1 || p0_data_o !== D_VAL) begin n_fail++; $display("FAIL rd17_resp: got v=%b %h want 1 %h", p0_v_o, p0_data_o, D_VAL); end
        for (int k = 0; k < 3; k++) begin
            step();
            settle();
            n_checks++; if (p0_v_o !== 1'b1 || p0_data_o !== D_VAL) begin n_fail++; $display("FAIL rd17_hold[%0d]: got v=%b %h want 1 %h", k, p0_v_o, p0_data_o, D_VAL); end
        end
        step();
        p0_yumi_i = 1'b1;
        settle();
        n_checks++; if (p0_v_o !== 1'b1) begin n_fail++; $display("FAIL rd17_consume_cycle: got v=%b want 1", p0_v_o); end
        step();
        p0_yumi_i = 1'b0;
        settle();
        n_checks++; if (p0_v_o !== 1'b0) begin n_fail++; $display("FAIL rd17_consumed: got v=%b want 0", p0_v_o); end
    endtask

    task automatic test_slot_full();
        step();
        p1_v = 1'b1; p1_w = 1'b0; p1_addr = 10'd17;
        settle();
        n_checks++; if (p1_yumi_o !== 1'b1) begin n_fail++; $display("FAIL full_first_accept: got %b want 1", p1_yumi_o); end
        step();
        p1_addr = 10'd3;
        settle();
        n_checks++; if (p1_yumi_o !== 1'b0) begin n_fail++; $display("FAIL full_pending_block: got %b want 0", p1_yumi_o); end
        step();
        settle();
        n_checks++;
        if (p1_yumi_o !== 1'b0 || p1_v_o !== 1'b1 || p1_data_o !== D_VAL) begin
            n_fail++; $display("FAIL full_slot_block: got yumi=%b v=%b %h want 0 1 %h", p1_yumi_o, p1_v_o, p1_data_o, D_VAL);
        end
        step();
        settle();
        n_checks++; if (p1_yumi_o !== 1'b0 || p1_data_o !== D_VAL) begin n_fail++; $display("FAIL full_hold: got yumi=%b %h want 0 %h", p1_yumi_o, p1_data_o, D_VAL); end
        step();
        p1_yumi_i = 1'b1;
        settle();
        n_checks++;
        if (p1_yumi_o !== 1'b1 || p1_data_o !== D_VAL || mem_addr !== 10'd3) begin
            n_fail++; $display("FAIL full_drain_accept: got yumi=%b %h addr=%0d want 1 %h 3", p1_yumi_o, p1_data_o, mem_addr, D_VAL);
        end
        step();
        p1_yumi_i = 1'b0; p1_v = 1'b0;
        settle();
        n_checks++; if (p1_v_o !== 1'b0) begin n_fail++; $display("FAIL full_gap: got v=%b want 0", p1_v_o); end
        step();
        settle();
        n_checks++; if (p1_v_o !== 1'b1 || p1_data_o !== A_VAL) begin n_fail++; $display("FAIL full_second_resp: got v=%b %h want 1 %h", p1_v_o, p1_data_o, A_VAL); end
        step();
        p1_yumi_i = 1'b1;
        step();
        p1_yumi_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t;
        p0_v = 1'b1; p0_w = 1'b0; p0_addr = 10'd17;
        settle();
        n_checks++; if (p0_yumi_o !== 1'b1) begin n_fail++; $display("FAIL rmid_accept: got %b want 1", p0_yumi_o); end
        step();
        p0_v = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (p0_v_o !== 1'b0 || p0_data_o !== '0 || p1_v_o !== 1'b0 || p1_data_o !== '0 ||
            p0_yumi_o !== 1'b0 || p1_yumi_o !== 1'b0 || mem_v !== 1'b0 || init_done !== 1'b0) begin
            n_fail++; $display("FAIL rmid_outputs: got v=%b%b d0=%h d1=%h yumi=%b%b mem_v=%b done=%b want all 0",
                               p0_v_o, p1_v_o, p0_data_o, p1_data_o, p0_yumi_o, p1_yumi_o, mem_v, init_done);
        end
        step();
        step();
        @(negedge clk);
        reset_n = 1'b1;
        t = 0;
        #1;
        while (init_done !== 1'b1 && t < 2000) begin
            n_checks++; if (p0_v_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ghost_init: got v=%b want 0", p0_v_o); end
            @(negedge clk);
            #1;
            t++;
        end
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL rmid_init_timeout: got done=%b want 1", init_done); end
        for (int k = 0; k < 3; k++) begin
            step();
            settle();
            n_checks++; if (p0_v_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ghost[%0d]: got v=%b want 0", k, p0_v_o); end
        end
    endtask

    task automatic test_back_to_back_raw();
        step();
        p0_v = 1'b1; p0_w = 1'b1; p0_addr = 10'd9; p0_data = E_VAL;
        p1_v = 1'b1; p1_w = 1'b0; p1_addr = 10'd9;
        settle();
        n_checks++;
        if (p0_yumi_o !== 1'b1 || p1_yumi_o !== 1'b0 || mem_w !== 1'b1 || mem_addr !== 10'd9) begin
            n_fail++; $display("FAIL raw_first: got yumi=%b%b w=%b addr=%0d want 10 1 9", p0_yumi_o, p1_yumi_o, mem_w, mem_addr);
        end
        step();
        p0_v = 1'b0;
        settle();
        n_checks++;
        if (p1_yumi_o !== 1'b1 || mem_w !== 1'b0 || mem_addr !== 10'd9) begin
            n_fail++; $display("FAIL raw_second: got yumi=%b w=%b addr=%0d want 1 0 9", p1_yumi_o, mem_w, mem_addr);
        end
        step();
        p1_v = 1'b0;
        step();
        settle();
        n_checks++; if (p1_v_o !== 1'b1 || p1_data_o !== E_VAL) begin n_fail++; $display("FAIL raw_data: got v=%b %h want 1 %h", p1_v_o, p1_data_o, E_VAL); end
        step();
        p1_yumi_i = 1'b1;
        step();
        p1_yumi_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_round_robin();
        test_write_read();
        test_slot_full();
        test_reset_mid();
        test_back_to_back_raw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
